alu_rs: RTL and testbench

Reservation station feeding the integer ALU in the Tomasulo core. Buffers up to `RS_SIZE` decoded ALU/branch/jump instructions from dispatch, snoops the CDB for outstanding operand tags, and issues one fully-ready entry per cycle on the registered ALU input bus (`ALU_S`, `Op`, `Vj`, `Vk`, `Reorder`, `A`, `pc`). The ALU is combinational and drives `CDB_ALU_*` in the same cycle.

---
 rtl/alu_rs_pkg.sv | 28 ++
 rtl/rs_prio_enc.sv | 29 ++
 rtl/alu_rs.sv | 175 +++++++++++++++++
 tb/tb_alu_rs.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: constants shared by the ALU reservation station and its users.
// Holds the enable/disable/null encodings, the bus widths and the internal
// opcode encodings (LUI .. AND) produced by the decoder.
package alu_rs_pkg;

    localparam int DATA_BUS_W = 32;
    localparam int ROB_BUS_W  = 4;
    localparam int OP_BUS_W   = 6;

    localparam logic        ENABLE  = 1'b1;
    localparam logic        DISABLE = 1'b0;
    localparam logic [31:0] NULL    = 32'd0;

    localparam logic [OP_BUS_W-1:0] OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,
                                    OP_JALR  = 6'd4,  OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,
                                    OP_BLT   = 6'd7,  OP_BGE   = 6'd8,  OP_BLTU  = 6'd9,
                                    OP_BGEU  = 6'd10, OP_LB    = 6'd11, OP_LH    = 6'd12,
                                    OP_LW    = 6'd13, OP_LBU   = 6'd14, OP_LHU   = 6'd15,
                                    OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
                                    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21,
                                    OP_XORI  = 6'd22, OP_ORI   = 6'd23, OP_ANDI  = 6'd24,
                                    OP_SLLI  = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27,
                                    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30,
                                    OP_SLT   = 6'd31, OP_SLTU  = 6'd32, OP_XOR   = 6'd33,
                                    OP_SRL   = 6'd34, OP_SRA   = 6'd35, OP_OR    = 6'd36,
                                    OP_AND   = 6'd37;

endpackage

// File: rtl/rs_prio_enc.sv
// rs_prio_enc: lowest-index set-bit encoder.
// Ports:
//   vec   in  N        request vector
//   idx   out log2(N)  index of the lowest set bit (0 when none)
//   found out 1        at least one bit of vec is set
module rs_prio_enc
    import alu_rs_pkg::*;
#(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = DISABLE;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = ENABLE;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Buffers up to RS_SIZE dispatched instructions, snoops the ALU and LSB CDB
// broadcasts for pending operand tags and issues the lowest-index ready entry
// each cycle on a registered bus.
// Ports:
//   clk, rst (async, active-low), rdy (global enable), Clear (flush)
//   Issue_*         dispatch write port (op, operands/tags, ROB tag, imm, pc)
//   RS_Full         combinational, every entry busy
//   CDB_ALU_*/LSB_* result broadcasts used for wakeup
//   ALU_S, Op, Vj, Vk, Reorder, A, pc   registered issue bus to the ALU
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int DATA_W  = DATA_BUS_W,
    parameter int ROB_W   = ROB_BUS_W,
    parameter int OP_W    = OP_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Clear,
    input  logic              Issue_S,
    input  logic [OP_W-1:0]   Issue_Op,
    input  logic [DATA_W-1:0] Issue_Vj,
    input  logic [DATA_W-1:0] Issue_Vk,
    input  logic              Issue_Qj_S,
    input  logic              Issue_Qk_S,
    input  logic [ROB_W-1:0]  Issue_Qj,
    input  logic [ROB_W-1:0]  Issue_Qk,
    input  logic [ROB_W-1:0]  Issue_Reorder,
    input  logic [DATA_W-1:0] Issue_A,
    input  logic [DATA_W-1:0] Issue_pc,
    output logic              RS_Full,
    input  logic              CDB_ALU_S,
    input  logic [ROB_W-1:0]  CDB_ALU_Reorder,
    input  logic [DATA_W-1:0] CDB_ALU_Value,
    input  logic              CDB_LSB_S,
    input  logic [ROB_W-1:0]  CDB_LSB_Reorder,
    input  logic [DATA_W-1:0] CDB_LSB_Value,
    output logic              ALU_S,
    output logic [OP_W-1:0]   Op,
    output logic [DATA_W-1:0] Vj,
    output logic [DATA_W-1:0] Vk,
    output logic [ROB_W-1:0]  Reorder,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] pc
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_s;
    logic [RS_SIZE-1:0] qk_s;
    logic [OP_W-1:0]    ent_op      [RS_SIZE];
    logic [DATA_W-1:0]  ent_vj      [RS_SIZE];
    logic [DATA_W-1:0]  ent_vk      [RS_SIZE];
    logic [ROB_W-1:0]   ent_qj      [RS_SIZE];
    logic [ROB_W-1:0]   ent_qk      [RS_SIZE];
    logic [ROB_W-1:0]   ent_reorder [RS_SIZE];
    logic [DATA_W-1:0]  ent_a       [RS_SIZE];
    logic [DATA_W-1:0]  ent_pc      [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   alloc_idx;
    logic               sel_found;
    logic               free_found;
    logic               alloc_en;

    // Readiness looks only at registered state, so a wakeup this cycle makes
    // the entry selectable next cycle.
    assign ready_vec = busy & ~qj_s & ~qk_s;
    assign free_vec  = ~busy;
    assign RS_Full   = ~free_found;
    assign alloc_en  = Issue_S & free_found;

    rs_prio_enc #(.N(RS_SIZE)) u_sel_enc (
        .vec   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    rs_prio_enc #(.N(RS_SIZE)) u_free_enc (
        .vec   (free_vec),
        .idx   (alloc_idx),
        .found (free_found)
    );

    // A pending operand is satisfied by either broadcast; the two never carry
    // the same tag in one cycle.
    function automatic logic cdb_hit(input logic pend, input logic [ROB_W-1:0] tag);
        return pend && ((CDB_ALU_S && (CDB_ALU_Reorder == tag)) ||
                        (CDB_LSB_S && (CDB_LSB_Reorder == tag)));
    endfunction

    function automatic logic [DATA_W-1:0] cdb_val(input logic pend, input logic [ROB_W-1:0] tag,
                                                  input logic [DATA_W-1:0] v);
        if (pend && CDB_LSB_S && (CDB_LSB_Reorder == tag)) return CDB_LSB_Value;
        if (pend && CDB_ALU_S && (CDB_ALU_Reorder == tag)) return CDB_ALU_Value;
        return v;
    endfunction

    // Control state and the issue bus. Select clears busy on the same edge it
    // drives the bus; allocation uses pre-edge busy, so a slot freed by this
    // edge's select cannot be refilled until the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= '0;
            qj_s    <= '0;
            qk_s    <= '0;
            ALU_S   <= DISABLE;
            Op      <= '0;
            Vj      <= '0;
            Vk      <= '0;
            Reorder <= '0;
            A       <= '0;
            pc      <= '0;
        end else if (rdy) begin
            if (Clear) begin
                busy    <= '0;
                ALU_S   <= DISABLE;
                Op      <= OP_W'(NULL);
                Vj      <= DATA_W'(NULL);
                Vk      <= DATA_W'(NULL);
                Reorder <= ROB_W'(NULL);
                A       <= DATA_W'(NULL);
                pc      <= DATA_W'(NULL);
            end else begin
                ALU_S   <= sel_found;
                Op      <= sel_found ? ent_op[sel_idx]      : OP_W'(NULL);
                Vj      <= sel_found ? ent_vj[sel_idx]      : DATA_W'(NULL);
                Vk      <= sel_found ? ent_vk[sel_idx]      : DATA_W'(NULL);
                Reorder <= sel_found ? ent_reorder[sel_idx] : ROB_W'(NULL);
                A       <= sel_found ? ent_a[sel_idx]       : DATA_W'(NULL);
                pc      <= sel_found ? ent_pc[sel_idx]      : DATA_W'(NULL);
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (sel_found && (sel_idx == IDX_W'(i))) begin
                        busy[i] <= DISABLE;
                    end else if (alloc_en && (alloc_idx == IDX_W'(i))) begin
                        busy[i] <= ENABLE;
                        qj_s[i] <= Issue_Qj_S & ~cdb_hit(Issue_Qj_S, Issue_Qj);
                        qk_s[i] <= Issue_Qk_S & ~cdb_hit(Issue_Qk_S, Issue_Qk);
                    end else if (busy[i]) begin
                        qj_s[i] <= qj_s[i] & ~cdb_hit(qj_s[i], ent_qj[i]);
                        qk_s[i] <= qk_s[i] & ~cdb_hit(qk_s[i], ent_qk[i]);
                    end
                end
            end
        end
    end

    // Entry payload. Never reset: contents only matter while busy is set.
    always_ff @(posedge clk) begin
        if (rdy && !Clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_en && (alloc_idx == IDX_W'(i))) begin
                    ent_op[i]      <= Issue_Op;
                    ent_vj[i]      <= cdb_val(Issue_Qj_S, Issue_Qj, Issue_Vj);
                    ent_vk[i]      <= cdb_val(Issue_Qk_S, Issue_Qk, Issue_Vk);
                    ent_qj[i]      <= Issue_Qj;
                    ent_qk[i]      <= Issue_Qk;
                    ent_reorder[i] <= Issue_Reorder;
                    ent_a[i]       <= Issue_A;
                    ent_pc[i]      <= Issue_pc;
                end else if (busy[i]) begin
                    ent_vj[i] <= cdb_val(qj_s[i], ent_qj[i], ent_vj[i]);
                    ent_vk[i] <= cdb_val(qk_s[i], ent_qk[i], ent_vk[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for alu_rs with a cycle-level behavioural model
// of the reservation station and hand-computed expectations.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          Clear = 1'b0;
    logic          Issue_S = 1'b0;
    logic [OW-1:0] Issue_Op = '0;
    logic [DW-1:0] Issue_Vj = '0, Issue_Vk = '0, Issue_A = '0, Issue_pc = '0;
    logic          Issue_Qj_S = 1'b0, Issue_Qk_S = 1'b0;
    logic [RW-1:0] Issue_Qj = '0, Issue_Qk = '0, Issue_Reorder = '0;
    logic          RS_Full;
    logic          CDB_ALU_S = 1'b0, CDB_LSB_S = 1'b0;
    logic [RW-1:0] CDB_ALU_Reorder = '0, CDB_LSB_Reorder = '0;
    logic [DW-1:0] CDB_ALU_Value = '0, CDB_LSB_Value = '0;
    logic          ALU_S;
    logic [OW-1:0] Op;
    logic [DW-1:0] Vj, Vk, A, pc;
    logic [RW-1:0] Reorder;

    always #5 clk = ~clk;

    alu_rs #(.RS_SIZE(N), .DATA_W(DW), .ROB_W(RW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear(Clear),
        .Issue_S(Issue_S), .Issue_Op(Issue_Op), .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk),
        .Issue_Qj_S(Issue_Qj_S), .Issue_Qk_S(Issue_Qk_S), .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
        .Issue_Reorder(Issue_Reorder), .Issue_A(Issue_A), .Issue_pc(Issue_pc),
        .RS_Full(RS_Full),
        .CDB_ALU_S(CDB_ALU_S), .CDB_ALU_Reorder(CDB_ALU_Reorder), .CDB_ALU_Value(CDB_ALU_Value),
        .CDB_LSB_S(CDB_LSB_S), .CDB_LSB_Reorder(CDB_LSB_Reorder), .CDB_LSB_Value(CDB_LSB_Value),
        .ALU_S(ALU_S), .Op(Op), .Vj(Vj), .Vk(Vk), .Reorder(Reorder), .A(A), .pc(pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          busy;
        logic [OW-1:0] op;
        logic [DW-1:0] vj, vk, a, pc;
        logic          qjs, qks;
        logic [RW-1:0] qj, qk, rob;
    } ent_t;

    ent_t          m  [N];
    ent_t          nx [N];
    logic          m_s, n_s;
    logic [OW-1:0] m_op, n_op;
    logic [DW-1:0] m_vj, m_vk, m_a, m_pc, n_vj, n_vk, n_a, n_pc;
    logic [RW-1:0] m_rob, n_rob;

    // Resolve an entry's pending operands against this cycle's broadcasts.
    function automatic ent_t snoop(input ent_t e,
                                   input logic as, input logic [RW-1:0] at, input logic [DW-1:0] av,
                                   input logic ls, input logic [RW-1:0] lt, input logic [DW-1:0] lv);
        ent_t r;
        r = e;
        if (r.qjs && as && at == r.qj) begin r.vj = av; r.qjs = 1'b0; end
        if (r.qjs && ls && lt == r.qj) begin r.vj = lv; r.qjs = 1'b0; end
        if (r.qks && as && at == r.qk) begin r.vk = av; r.qks = 1'b0; end
        if (r.qks && ls && lt == r.qk) begin r.vk = lv; r.qks = 1'b0; end
        return r;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    always_comb begin
        int   sel;
        int   fr;
        ent_t ne;
        sel = -1;
        fr  = -1;
        ne  = '0;
        n_s = 1'b0; n_op = '0; n_vj = '0; n_vk = '0; n_a = '0; n_pc = '0; n_rob = '0;
        for (int i = 0; i < N; i++) nx[i] = m[i];
        if (Clear) begin
            for (int i = 0; i < N; i++) nx[i].busy = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sel < 0 && m[i].busy && !m[i].qjs && !m[i].qks) sel = i;
                if (fr < 0 && !m[i].busy) fr = i;
            end
            if (sel >= 0) begin
                n_s = 1'b1; n_op = m[sel].op; n_vj = m[sel].vj; n_vk = m[sel].vk;
                n_a = m[sel].a; n_pc = m[sel].pc; n_rob = m[sel].rob;
            end
            for (int i = 0; i < N; i++)
                if (m[i].busy)
                    nx[i] = snoop(m[i], CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
                                  CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value);
            if (sel >= 0) nx[sel].busy = 1'b0;
            if (Issue_S && fr >= 0) begin
                ne.busy = 1'b1; ne.op = Issue_Op; ne.vj = Issue_Vj; ne.vk = Issue_Vk;
                ne.qjs = Issue_Qj_S; ne.qks = Issue_Qk_S; ne.qj = Issue_Qj; ne.qk = Issue_Qk;
                ne.rob = Issue_Reorder; ne.a = Issue_A; ne.pc = Issue_pc;
                nx[fr] = snoop(ne, CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
                               CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value);
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) m[i] <= '0;
            m_s <= 1'b0; m_op <= '0; m_vj <= '0; m_vk <= '0; m_a <= '0; m_pc <= '0; m_rob <= '0;
        end else if (rdy) begin
            for (int i = 0; i < N; i++) m[i] <= nx[i];
            m_s <= n_s; m_op <= n_op; m_vj <= n_vj; m_vk <= n_vk;
            m_a <= n_a; m_pc <= n_pc; m_rob <= n_rob;
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("cmp_alu_s",   32'(ALU_S),   32'(m_s));
            chk("cmp_op",      32'(Op),      32'(m_op));
            chk("cmp_vj",      Vj,           m_vj);
            chk("cmp_vk",      Vk,           m_vk);
            chk("cmp_a",       A,            m_a);
            chk("cmp_pc",      pc,           m_pc);
            chk("cmp_reorder", 32'(Reorder), 32'(m_rob));
            chk("cmp_rs_full", 32'(RS_Full), 32'(m_full()));
            chk("issue_while_full", 32'(Issue_S & RS_Full), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Issue_S = 1'b0; Issue_Qj_S = 1'b0; Issue_Qk_S = 1'b0;
        CDB_ALU_S = 1'b0; CDB_LSB_S = 1'b0; Clear = 1'b0;
    endtask

    task automatic iss(input logic [OW-1:0] op, input logic [DW-1:0] vj, input logic qjs,
                       input logic [RW-1:0] qj, input logic [DW-1:0] vk, input logic qks,
                       input logic [RW-1:0] qk, input logic [RW-1:0] rob, input logic [DW-1:0] a);
        Issue_S = 1'b1; Issue_Op = op; Issue_Vj = vj; Issue_Qj_S = qjs; Issue_Qj = qj;
        Issue_Vk = vk; Issue_Qk_S = qks; Issue_Qk = qk; Issue_Reorder = rob; Issue_A = a;
        Issue_pc = 32'h1000 + (32'(rob) << 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_alu_s",   32'(ALU_S),   32'd0);
        chk("rst_rs_full", 32'(RS_Full), 32'd0);
        chk("rst_op",      32'(Op),      32'd0);
        chk("rst_vj",      Vj,           32'd0);
        chk("rst_reorder", 32'(Reorder), 32'd0);
        #4 rst = 1'b1;
        cyc();

        // ADDI with ready operand: ALU_S one cycle after the issue edge
        iss(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 32'd7);
        cyc(); idle();
        chk("t1_pre_alu_s", 32'(ALU_S), 32'd0);
        cyc();
        chk("t1_alu_s",   32'(ALU_S),   32'd1);
        chk("t1_op",      32'(Op),      32'(OP_ADDI));
        chk("t1_vj",      Vj,           32'd5);
        chk("t1_a",       A,            32'd7);
        chk("t1_reorder", 32'(Reorder), 32'd3);
        chk("t1_pc",      pc,           32'h100C);
        cyc();
        chk("t1_alu_s_off", 32'(ALU_S), 32'd0);

        // Pending Qj woken by LSB broadcast two cycles after issue
        iss(OP_ADD, 32'hDEAD, 1'b1, 4'd2, 32'd4, 1'b0, 4'd0, 4'd5, 32'd0);
        cyc(); idle();
        cyc(); cyc();
        CDB_LSB_S = 1'b1; CDB_LSB_Reorder = 4'd2; CDB_LSB_Value = 32'd10;
        cyc(); idle();
        chk("t2_wait", 32'(ALU_S), 32'd0);
        cyc();
        chk("t2_alu_s",   32'(ALU_S),   32'd1);
        chk("t2_vj",      Vj,           32'd10);
        chk("t2_vk",      Vk,           32'd4);
        chk("t2_reorder", 32'(Reorder), 32'd5);
        cyc();

        // Qk satisfied by the ALU broadcast in the same cycle as dispatch
        iss(OP_SUB, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd8, 32'd0);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd6; CDB_ALU_Value = 32'hFFFF_FFFF;
        cyc(); idle();
        cyc();
        chk("t3_alu_s",   32'(ALU_S),   32'd1);
        chk("t3_vk",      Vk,           32'hFFFF_FFFF);
        chk("t3_reorder", 32'(Reorder), 32'd8);
        cyc();

        // Fill every entry pending on tag 1, then drain in index order
        for (int k = 0; k < N; k++) begin
            iss(OP_ADD, 32'd0, 1'b1, 4'd1, 32'(k), 1'b0, 4'd0, 4'(k), 32'd0);
            cyc();
        end
        idle();
        chk("t4_full", 32'(RS_Full), 32'd1);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd1; CDB_ALU_Value = 32'h11;
        cyc(); idle();
        chk("t4_full_after_wake", 32'(RS_Full), 32'd1);
        chk("t4_no_issue_yet",    32'(ALU_S),   32'd0);
        for (int k = 0; k < N; k++) begin
            cyc();
            chk("t4_alu_s", 32'(ALU_S),   32'd1);
            chk("t4_order", 32'(Reorder), 32'(k));
            chk("t4_vj",    Vj,           32'h11);
            if (k == 0) chk("t4_full_drop", 32'(RS_Full), 32'd0);
        end
        cyc();
        chk("t4_drained", 32'(ALU_S), 32'd0);

        // Clear with 5 busy entries and a simultaneous dispatch
        for (int k = 0; k < 5; k++) begin
            iss(OP_XOR, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 4'(k), 32'd0);
            cyc();
        end
        idle();
        chk("t5_not_full", 32'(RS_Full), 32'd0);
        iss(OP_OR, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd12, 32'd0);
        Clear = 1'b1;
        cyc(); idle();
        chk("t5_alu_s", 32'(ALU_S),   32'd0);
        chk("t5_full",  32'(RS_Full), 32'd0);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd9; CDB_ALU_Value = 32'd1;
        cyc(); idle();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_quiet", 32'(ALU_S), 32'd0);
        end

        // rdy freeze: B pending on tag 5, A and C ready
        iss(OP_AND, 32'd0, 1'b1, 4'd5, 32'h66, 1'b0, 4'd0, 4'd10, 32'd0);
        cyc();
        iss(OP_ADDI, 32'h21, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd4, 32'd1);
        cyc();
        iss(OP_OR, 32'h77, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd7, 32'd0);
        cyc(); idle();
        chk("t6_pre_alu_s",   32'(ALU_S),   32'd1);
        chk("t6_pre_reorder", 32'(Reorder), 32'd4);
        rdy = 1'b0;
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd5; CDB_ALU_Value = 32'h55;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_frz_alu_s",   32'(ALU_S),   32'd1);
            chk("t6_frz_reorder", 32'(Reorder), 32'd4);
            chk("t6_frz_vj",      Vj,           32'h21);
        end
        rdy = 1'b1; idle();
        cyc();
        chk("t6_res_alu_s",   32'(ALU_S),   32'd1);
        chk("t6_res_reorder", 32'(Reorder), 32'd7);
        cyc();
        chk("t6_res_idle", 32'(ALU_S), 32'd0);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd5; CDB_ALU_Value = 32'h55;
        cyc(); idle();
        cyc();
        chk("t6_wake_alu_s",   32'(ALU_S),   32'd1);
        chk("t6_wake_vj",      Vj,           32'h55);
        chk("t6_wake_vk",      Vk,           32'h66);
        chk("t6_wake_reorder", 32'(Reorder), 32'd10);
        cyc();

        // Asynchronous reset mid-cycle while ALU_S is high
        iss(OP_LUI, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd2, 32'h1234_5000);
        iss(OP_LUI, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd2, 32'h1234_5000);
        cyc(); idle();
        cyc();
        chk("t7_pre_alu_s", 32'(ALU_S), 32'd1);
        chk("t7_pre_a",     A,          32'h1234_5000);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_alu_s",   32'(ALU_S),   32'd0);
        chk("t7_rst_op",      32'(Op),      32'd0);
        chk("t7_rst_a",       A,            32'd0);
        chk("t7_rst_reorder", 32'(Reorder), 32'd0);
        chk("t7_rst_full",    32'(RS_Full), 32'd0);
        #2 rst = 1'b1;
        cyc();
        chk("t7_after_alu_s", 32'(ALU_S), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
